pair_sched: RTL and testbench

PAIR_SCHED -- requirements
Module: pair_sched

---
 rtl/pair_sched.sv | 212 +++++++++++++++++++++
 tb/tb_pair_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pair_sched.sv
// pair_sched: walks every unordered pair of object slots, presents each pair's
// position/velocity operands to an external collision detector and gathers the
// per-pair result bits into coll_map.
// Optional build macro: PAIR_SCHED_TIMEOUT_EN adds a per-pair watchdog and an
// err output; without it the block waits indefinitely for the detector.
//
// state | meaning
// IDLE  | waiting for start; object table writable
// RUN   | pairs being issued to the detector, det_in_rdy high
// FIN   | single completion cycle, done high
module pair_sched #(
    parameter  int N_OBJ = 8,
    localparam int NPAIR = N_OBJ * (N_OBJ - 1) / 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ld_we,
    input  logic [2:0]       ld_addr,
    input  logic [15:0]      ld_x,
    input  logic [15:0]      ld_y,
    input  logic [15:0]      ld_vx,
    input  logic [15:0]      ld_vy,
    input  logic [15:0]      cfg_r2,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [NPAIR-1:0] coll_map,
    output logic [4:0]       hit_cnt,
    output logic [15:0]      x1,
    output logic [15:0]      y1,
    output logic [15:0]      vx1,
    output logic [15:0]      vy1,
    output logic [15:0]      x2,
    output logic [15:0]      y2,
    output logic [15:0]      vx2,
    output logic [15:0]      vy2,
    output logic [15:0]      r2,
    output logic             det_in_rdy,
    input  logic             det_trial,
    input  logic             det_out_rdy
`ifdef PAIR_SCHED_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    localparam int KW = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] vx;
        logic [15:0] vy;
    } obj_t;

    state_t        state_q, state_d;
    obj_t          slot_q [N_OBJ];
    obj_t          slot_v [N_OBJ];
    obj_t          op_a, op_b;
    logic [2:0]    pi_q, pj_q, ni, nj, sel_i, sel_j;
    logic [KW-1:0] k_q;
    logic          drain_q, last_pair, wr_ok;
    logic          go, take, discard, fin;
`ifdef PAIR_SCHED_TIMEOUT_EN
    logic [4:0]    wd_q;
    logic          abort;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign last_pair = (int'(k_q) == NPAIR - 1);

    // Table view with this cycle's write folded in, so a start in the same
    // cycle as a load already sees the new slot contents.
    always_comb begin
        wr_ok = ld_we && (state_q == IDLE) && (int'(ld_addr) < N_OBJ);
        for (int s = 0; s < N_OBJ; s++) begin
            slot_v[s] = slot_q[s];
            if (wr_ok && (int'(ld_addr) == s))
                slot_v[s] = {ld_x, ld_y, ld_vx, ld_vy};
        end
    end

    // Next pair in (0,1),(0,2)..(N-2,N-1) order and the operands it selects.
    always_comb begin
        if (pj_q == 3'(N_OBJ - 1)) begin
            ni = pi_q + 3'd1;
            nj = pi_q + 3'd2;
        end else begin
            ni = pi_q;
            nj = pj_q + 3'd1;
        end
        sel_i = (state_q == IDLE) ? 3'd0 : ni;
        sel_j = (state_q == IDLE) ? 3'd1 : nj;
        op_a  = '0;
        op_b  = '0;
        for (int s = 0; s < N_OBJ; s++) begin
            if (3'(s) == sel_i) op_a = slot_v[s];
            if (3'(s) == sel_j) op_b = slot_v[s];
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        take    = 1'b0;
        discard = 1'b0;
        fin     = 1'b0;
`ifdef PAIR_SCHED_TIMEOUT_EN
        abort   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    go      = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (det_out_rdy) begin
                    // First completion after a reset mid-scan belongs to the
                    // detector's stale pass, not to pair 0.
                    if (drain_q) begin
                        discard = 1'b1;
                    end else begin
                        take = 1'b1;
                        if (last_pair) begin
                            fin     = 1'b1;
                            state_d = FIN;
                        end
                    end
                end
`ifdef PAIR_SCHED_TIMEOUT_EN
                else if (wd_q == 5'd15) begin
                    abort   = 1'b1;
                    state_d = FIN;
                end
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Object table, pair walk, operand registers and result accumulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < N_OBJ; s++) slot_q[s] <= '0;
            coll_map               <= '0;
            hit_cnt                <= '0;
            {x1, y1, vx1, vy1}     <= '0;
            {x2, y2, vx2, vy2}     <= '0;
            r2                     <= '0;
            det_in_rdy             <= 1'b0;
            pi_q                   <= '0;
            pj_q                   <= '0;
            k_q                    <= '0;
            drain_q                <= (state_q == RUN);
`ifdef PAIR_SCHED_TIMEOUT_EN
            wd_q                   <= '0;
            err                    <= 1'b0;
`endif
        end else begin
            slot_q <= slot_v;
            if (go) begin
                coll_map           <= '0;
                hit_cnt            <= '0;
                k_q                <= '0;
                pi_q               <= 3'd0;
                pj_q               <= 3'd1;
                {x1, y1, vx1, vy1} <= op_a;
                {x2, y2, vx2, vy2} <= op_b;
                r2                 <= cfg_r2;
                det_in_rdy         <= 1'b1;
            end
            if (discard) drain_q <= 1'b0;
            if (take) begin
                coll_map[k_q] <= det_trial;
                hit_cnt       <= hit_cnt + 5'(det_trial);
                if (fin) begin
                    det_in_rdy <= 1'b0;
                end else begin
                    k_q                <= k_q + KW'(1);
                    pi_q               <= ni;
                    pj_q               <= nj;
                    {x1, y1, vx1, vy1} <= op_a;
                    {x2, y2, vx2, vy2} <= op_b;
                end
            end
`ifdef PAIR_SCHED_TIMEOUT_EN
            if (go || discard || take) wd_q <= '0;
            else if (state_q == RUN)   wd_q <= wd_q + 5'd1;
            if (go) begin
                err <= 1'b0;
            end else if (abort) begin
                err        <= 1'b1;
                det_in_rdy <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pair_sched.sv
// Bench for pair_sched: behavioural detector (10 enabled cycles per pair, no
// reset of its own), table of whole-scan vectors, plus hand-written sequences
// for in-scan pokes, reset mid-scan and the optional watchdog.
module tb_pair_sched;
    localparam int N_OBJ = 8;
    localparam int NPAIR = 28;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             ld_we = 1'b0;
    logic [2:0]       ld_addr = '0;
    logic [15:0]      ld_x = '0, ld_y = '0, ld_vx = '0, ld_vy = '0;
    logic [15:0]      cfg_r2 = '0;
    logic             start = 1'b0;
    logic             busy, done, det_in_rdy, det_trial, det_out_rdy;
    logic [NPAIR-1:0] coll_map;
    logic [4:0]       hit_cnt;
    logic [15:0]      x1, y1, vx1, vy1, x2, y2, vx2, vy2, r2;
`ifdef PAIR_SCHED_TIMEOUT_EN
    logic             err;
`endif

    pair_sched #(.N_OBJ(N_OBJ)) dut (
        .clock(clock), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_x(ld_x), .ld_y(ld_y), .ld_vx(ld_vx), .ld_vy(ld_vy), .cfg_r2(cfg_r2),
        .start(start), .busy(busy), .done(done), .coll_map(coll_map), .hit_cnt(hit_cnt),
        .x1(x1), .y1(y1), .vx1(vx1), .vy1(vy1), .x2(x2), .y2(y2), .vx2(vx2), .vy2(vy2),
        .r2(r2), .det_in_rdy(det_in_rdy), .det_trial(det_trial), .det_out_rdy(det_out_rdy)
`ifdef PAIR_SCHED_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clock = ~clock;

    int               checks = 0;
    int               errors = 0;
    logic [15:0]      sx [N_OBJ], sy [N_OBJ], svx [N_OBJ], svy [N_OBJ];
    int               i_of [NPAIR], j_of [NPAIR];
    logic [NPAIR-1:0] cur_mask = '0;
    logic [15:0]      cur_r2 = '0;
    int               cap_idx = 0;
    int               dcnt = 0;
    bit               det_stuck = 1'b0;

    // Detector: completes on its 10th enabled cycle; the result is the mask
    // bit of the pair it captured on its first enabled cycle.
    always @(posedge clock)
        if (det_in_rdy && !det_stuck) dcnt <= (dcnt == 9) ? 0 : dcnt + 1;

    assign det_out_rdy = det_in_rdy && !det_stuck && (dcnt == 9);
    assign det_trial   = det_out_rdy && cur_mask[cap_idx];

    typedef struct {
        bit               ld;
        logic [2:0]       addr;
        logic [63:0]      val;
        logic [NPAIR-1:0] mask;
        logic [15:0]      r2v;
        logic [NPAIR-1:0] exp_map;
        logic [4:0]       exp_hit;
        int               exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Runs one scan; lat counts the start cycle through the done cycle.
    // poke_at / reset_at name a cycle (start cycle = 0) for an in-scan event.
    task automatic run_scan(input bit do_ld, input logic [2:0] addr, input logic [63:0] val,
                            input logic [NPAIR-1:0] mask, input logic [15:0] r2v,
                            input int poke_at, input int reset_at, output int lat);
        int cyc;
        int exp_k;
        cur_mask = mask;
        cur_r2   = r2v;
        exp_k    = 0;
        cfg_r2   = r2v;
        start    = 1'b1;
        if (do_ld) begin
            ld_we = 1'b1;
            ld_addr = addr;
            {ld_x, ld_y, ld_vx, ld_vy} = val;
            {sx[addr], sy[addr], svx[addr], svy[addr]} = val;
        end
        tick();
        start  = 1'b0;
        ld_we  = 1'b0;
        cfg_r2 = ~r2v;
        cyc    = 1;
        while (!done && cyc < 400) begin
            if (det_in_rdy && !det_stuck && dcnt == 0) begin
                if (exp_k < NPAIR) begin
                    check($sformatf("operands pair %0d", exp_k),
                          {x1, y1, vx1, vy1, x2, y2, vx2, vy2, r2},
                          {sx[i_of[exp_k]], sy[i_of[exp_k]], svx[i_of[exp_k]], svy[i_of[exp_k]],
                           sx[j_of[exp_k]], sy[j_of[exp_k]], svx[j_of[exp_k]], svy[j_of[exp_k]],
                           cur_r2});
                    cap_idx = exp_k;
                end
                exp_k++;
            end
            if (cyc == poke_at) begin
                start = 1'b1;
                ld_we = 1'b1;
                ld_addr = 3'd3;
                {ld_x, ld_y, ld_vx, ld_vy} = 64'hDEAD_BEEF_5555_AAAA;
            end
            if (cyc == reset_at) begin
                reset = 1'b1;
                tick();
                lat = -1;
                return;
            end
            tick();
            start = 1'b0;
            ld_we = 1'b0;
            cyc++;
        end
        check("done reached", done, 1'b1);
        check("busy in FIN", busy, 1'b1);
        lat = cyc + 1;
    endtask

    task automatic after_scan(input string tag, input logic [NPAIR-1:0] exp_map,
                              input logic [4:0] exp_hit);
        check({tag, " coll_map"}, coll_map, exp_map);
        check({tag, " hit_cnt"}, hit_cnt, exp_hit);
        tick();
        check({tag, " done one cycle"}, {done, busy}, 2'b00);
        tick();
        tick();
        check({tag, " map held"}, {coll_map, hit_cnt}, {exp_map, exp_hit});
    endtask

    initial begin
        int lat;
        int k;
        k = 0;
        for (int i = 0; i < N_OBJ; i++)
            for (int j = i + 1; j < N_OBJ; j++) begin
                i_of[k] = i;
                j_of[k] = j;
                k++;
            end

        vecs[0] = '{ld: 0, addr: 3'd0, val: 64'h0, mask: 28'h0000001, r2v: 16'h0040,
                    exp_map: 28'h0000001, exp_hit: 5'd1, exp_lat: 282};
        vecs[1] = '{ld: 0, addr: 3'd0, val: 64'h0, mask: 28'hFFFFFFF, r2v: 16'h0100,
                    exp_map: 28'hFFFFFFF, exp_hit: 5'd28, exp_lat: 282};
        vecs[2] = '{ld: 1, addr: 3'd7, val: 64'h0123_0456_0007_FFF9, mask: 28'h8000000,
                    r2v: 16'h0021, exp_map: 28'h8000000, exp_hit: 5'd1, exp_lat: 282};
        vecs[3] = '{ld: 1, addr: 3'd0, val: 64'h0AAA_0BBB_0001_0002, mask: 28'h0000000,
                    r2v: 16'h7FFF, exp_map: 28'h0000000, exp_hit: 5'd0, exp_lat: 282};
        vecs[4] = '{ld: 1, addr: 3'd1, val: 64'h0CCC_0DDD_FFFE_0003, mask: 28'hA5A5A5A,
                    r2v: 16'h1234, exp_map: 28'hA5A5A5A, exp_hit: 5'd14, exp_lat: 282};

        tick();
        tick();
        check("reset status", {busy, done, det_in_rdy, coll_map, hit_cnt}, 160'd0);
        check("reset operands", {x1, y1, vx1, vy1, x2, y2, vx2, vy2, r2}, 160'd0);
        reset = 1'b0;
        tick();

        // Slots 0 and 1 approach each other; the rest sit far apart.
        for (int s = 0; s < N_OBJ; s++) begin
            sx[s]  = (s == 0) ? 16'd100 : (s == 1) ? 16'd120 : 16'(1000 * s);
            sy[s]  = 16'(50 + 700 * s);
            svx[s] = (s == 0) ? 16'd5 : (s == 1) ? 16'hFFFB : 16'(s);
            svy[s] = 16'hF000 | 16'(s);
            ld_we = 1'b1;
            ld_addr = 3'(s);
            {ld_x, ld_y, ld_vx, ld_vy} = {sx[s], sy[s], svx[s], svy[s]};
            tick();
        end
        ld_we = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            run_scan(vecs[v].ld, vecs[v].addr, vecs[v].val, vecs[v].mask, vecs[v].r2v, 0, 0, lat);
            check($sformatf("vec %0d latency", v), lat, vecs[v].exp_lat);
            after_scan($sformatf("vec %0d", v), vecs[v].exp_map, vecs[v].exp_hit);
        end

        // start and ld_we pulsed mid-scan are ignored.
        run_scan(1'b0, 3'd0, 64'h0, 28'h0000010, 16'h0055, 5, 0, lat);
        check("poke latency", lat, 282);
        after_scan("poke", 28'h0000010, 5'd1);

        // Reset while pair 5 is in the detector, then a clean restart.
        run_scan(1'b0, 3'd0, 64'h0, 28'h1234566, 16'h0077, 0, 55, lat);
        check("reset mid-scan status", {busy, done, det_in_rdy, coll_map, hit_cnt}, 160'd0);
        check("reset mid-scan operands", {x1, y1, vx1, vy1, x2, y2, vx2, vy2, r2}, 160'd0);
        reset = 1'b0;
        for (int s = 0; s < N_OBJ; s++) begin
            sx[s] = '0; sy[s] = '0; svx[s] = '0; svy[s] = '0;
        end
        tick();
        run_scan(1'b1, 3'd2, 64'h0222_0333_0004_0005, 28'h1234566, 16'h0077, 0, 0, lat);
        check("drain latency", lat, 287);
        after_scan("drain", 28'h1234566, 5'd11);

`ifdef PAIR_SCHED_TIMEOUT_EN
        det_stuck = 1'b1;
        run_scan(1'b0, 3'd0, 64'h0, 28'h0, 16'h0010, 0, 0, lat);
        check("timeout cycles after issue", lat - 1, 17);
        check("err on abort", err, 1'b1);
        tick();
        det_stuck = 1'b0;
        tick();
        run_scan(1'b0, 3'd0, 64'h0, 28'h0000003, 16'h0010, 0, 0, lat);
        check("post-timeout latency", lat, 282);
        check("err cleared by start", err, 1'b0);
        after_scan("post-timeout", 28'h0000003, 5'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
